// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - signed product accumulator with result handshake
//
// Sums LEN signed 16-bit products into an ACC_W-bit two's complement
// accumulator, then holds the completed sum until the consumer takes it.
//
// Optional build macro: MAC_ACCUMULATOR_SATURATE_EN
//   defined   -> an overflowing add clamps acc to the signed max/min
//   undefined -> acc wraps modulo 2^ACC_W
//   out_ovf behaves the same in both builds.
//
// Parameters:
//   ACC_W      accumulator width in bits (16..48)
//   LEN        products summed per result (1..255)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_prod holds a valid product
//   in_ready   block can accept a product this cycle
//   in_prod    signed 16-bit product
//   out_valid  out_acc holds a completed sum
//   out_ready  consumer takes the result this cycle
//   out_acc    accumulator value (partial sums visible during accumulation)
//   out_ovf    sticky signed-overflow flag for the current sum

module mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    typedef enum logic {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum;
    logic [7:0]         count_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               add_ovf;
    logic               accept;
    logic               last;

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    always_comb begin
        // Size-casting a signed value sign-extends it to the accumulator width.
        prod_ext = ACC_W'($signed(in_prod));
        sum      = acc_q + prod_ext;
        // Overflow only when both operands share a sign and the result flips it.
        add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);
        acc_d    = sum;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        // Operand sign tells the overflow direction: positive operands overflow up.
        if (add_ovf) begin
            acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
`endif
        accept   = in_valid && in_ready_q;
        last     = (count_q == 8'(LEN - 1));
    end

    // Handshake outputs are registered alongside the state so they decode
    // nothing combinationally and always agree with the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        count_q <= 8'(count_q + 8'd1);
                        if (add_ovf) begin
                            ovf_q <= 1'b1;
                        end
                        if (last) begin
                            state_q     <= S_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // in_valid is ignored here; only the consumer can release HOLD.
                    if (out_ready) begin
                        state_q     <= S_ACC;
                        acc_q       <= '0;
                        count_q     <= '0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - self-checking bench for mac_accumulator

module tb_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        out_ready;

    logic        rdy0, rdy1, rdy2, rdy3;
    logic        vld0, vld1, vld2, vld3;
    logic        ovf0, ovf1, ovf2, ovf3;
    logic [23:0] acc0;
    logic [15:0] acc1;
    logic [23:0] acc2;
    logic [15:0] acc3;

    int n_tests = 0;
    int n_fail  = 0;

    // Four configurations share one input stream; each has its own model.
    localparam int NI = 4;
    int     lens[NI] = '{8, 4, 2, 1};
    int     ws[NI]   = '{24, 16, 24, 16};

    longint m_acc[NI];
    int     m_cnt[NI];
    bit     m_hold[NI];
    bit     m_ovf[NI];

    bit     d_rdy[NI];
    bit     d_vld[NI];
    bit     d_ovf[NI];
    longint d_acc[NI];

    mac_accumulator #(.ACC_W(24), .LEN(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_prod(in_prod), .out_valid(vld0), .out_ready(out_ready),
        .out_acc(acc0), .out_ovf(ovf0));
    mac_accumulator #(.ACC_W(16), .LEN(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_prod(in_prod), .out_valid(vld1), .out_ready(out_ready),
        .out_acc(acc1), .out_ovf(ovf1));
    mac_accumulator #(.ACC_W(24), .LEN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_prod(in_prod), .out_valid(vld2), .out_ready(out_ready),
        .out_acc(acc2), .out_ovf(ovf2));
    mac_accumulator #(.ACC_W(16), .LEN(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
        .in_prod(in_prod), .out_valid(vld3), .out_ready(out_ready),
        .out_acc(acc3), .out_ovf(ovf3));

    always_comb begin
        d_rdy[0] = rdy0; d_vld[0] = vld0; d_ovf[0] = ovf0; d_acc[0] = longint'($signed(acc0));
        d_rdy[1] = rdy1; d_vld[1] = vld1; d_ovf[1] = ovf1; d_acc[1] = longint'($signed(acc1));
        d_rdy[2] = rdy2; d_vld[2] = vld2; d_ovf[2] = ovf2; d_acc[2] = longint'($signed(acc2));
        d_rdy[3] = rdy3; d_vld[3] = vld3; d_ovf[3] = ovf3; d_acc[3] = longint'($signed(acc3));
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: each accepted product is added with exact integer arithmetic,
    // then a result outside the signed range is flagged and wrapped or clamped.
    task automatic model_update(input bit r, input bit v, input longint p, input bit ordy);
        longint t, lo, hi, span;
        for (int k = 0; k < NI; k++) begin
            span = 64'sd1 <<< ws[k];
            hi   = (span / 2) - 1;
            lo   = -(span / 2);
            if (!r) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
            end else if (m_hold[k]) begin
                if (ordy) begin
                    m_acc[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
                end
            end else if (v) begin
                t = m_acc[k] + p;
                if (t > hi || t < lo) begin
                    m_ovf[k] = 1;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
                    t = (t > hi) ? hi : lo;
`else
                    t = (t > hi) ? t - span : t + span;
`endif
                end
                m_acc[k] = t;
                m_cnt[k]++;
                if (m_cnt[k] == lens[k]) m_hold[k] = 1;
            end
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("model_acc_i%0d", k), d_acc[k], m_acc[k]);
            chk($sformatf("model_rdy_vld_ovf_i%0d", k),
                longint'({d_rdy[k], d_vld[k], d_ovf[k]}),
                longint'({!m_hold[k], m_hold[k], m_ovf[k]}));
        end
    endtask

    // Drive one cycle of inputs, advance the model with the edge, sample #1 later.
    task automatic step(input bit r, input bit v, input logic signed [15:0] p, input bit ordy);
        rst_n = r; in_valid = v; in_prod = p; out_ready = ordy;
        @(posedge clk);
        model_update(r, v, longint'(p), ordy);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        step(0, 0, 16'sd0, 0);
    endtask

    typedef struct {
        bit      rst_n;
        bit      vld;
        shortint prod;
        bit      ordy;
        bit      e_rdy;
        bit      e_vld;
        longint  e_acc;
        bit      e_ovf;
    } vec_t;

    vec_t tbl[8];

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
        end
        rst_n = 0; in_valid = 0; in_prod = '0; out_ready = 0;

        // Table: expected outputs of the ACC_W=16, LEN=4 instance after each edge.
        tbl[0] = '{0, 1, 16384, 0, 1, 0, 0, 0};
        tbl[1] = '{0, 1, 16384, 0, 1, 0, 0, 0};
        tbl[2] = '{1, 1, 16384, 0, 1, 0, 16384, 0};
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        tbl[3] = '{1, 1, 16384, 0, 1, 0, 32767, 1};
        tbl[4] = '{1, 1, 16384, 0, 1, 0, 32767, 1};
        tbl[5] = '{1, 1, 16384, 0, 0, 1, 32767, 1};
        tbl[6] = '{1, 1, 16384, 0, 0, 1, 32767, 1};
`else
        tbl[3] = '{1, 1, 16384, 0, 1, 0, -32768, 1};
        tbl[4] = '{1, 1, 16384, 0, 1, 0, -16384, 1};
        tbl[5] = '{1, 1, 16384, 0, 0, 1, 0, 1};
        tbl[6] = '{1, 1, 16384, 0, 0, 1, 0, 1};
`endif
        tbl[7] = '{1, 0, 16384, 1, 1, 0, 0, 0};

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rst_n, tbl[i].vld, 16'(tbl[i].prod), tbl[i].ordy);
            chk($sformatf("tbl%0d_acc", i), d_acc[1], tbl[i].e_acc);
            chk($sformatf("tbl%0d_flags", i),
                longint'({d_rdy[1], d_vld[1], d_ovf[1]}),
                longint'({tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_ovf}));
        end

        // Eight back-to-back products of 16129 on the LEN=8 instance.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 16'sd16129, 0);
            if (i == 6) chk("sum_valid_before_last", longint'(d_vld[0]), 0);
        end
        chk("sum_valid", longint'(d_vld[0]), 1);
        chk("sum_acc", d_acc[0], 129032);
        chk("sum_ovf", longint'(d_ovf[0]), 0);

        // Bubbles between accepts, then backpressure in HOLD.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            if (i % 2 == 0) step(1, 1, 16'sd100, 0);
            else            step(1, 0, 16'($urandom), 0);
            chk($sformatf("bubble_acc_%0d", i), d_acc[0], longint'(100 * (i / 2 + 1)));
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 16'sd555, 0);
            chk($sformatf("bp_acc_%0d", i), d_acc[0], 800);
            chk($sformatf("bp_rdy_vld_%0d", i), longint'({d_rdy[0], d_vld[0]}), 1);
        end
        step(1, 0, 16'sd0, 1);
        chk("release_rdy", longint'(d_rdy[0]), 1);
        chk("release_acc", d_acc[0], 0);

        // Reset in the middle of a sum discards the partial result.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 16'sd1000, 0);
        step(0, 1, 16'sd1000, 0);
        chk("midrst_acc", d_acc[0], 0);
        for (int i = 0; i < 8; i++) step(1, 1, 16'sd1, 0);
        chk("midrst_final", d_acc[0], 8);
        chk("midrst_valid", longint'(d_vld[0]), 1);

        // Negative products on the LEN=2 instance.
        do_reset();
        step(1, 1, -16'sd16256, 0);
        step(1, 1, -16'sd16256, 0);
        chk("neg_acc", d_acc[2], -32512);
        chk("neg_valid_ovf", longint'({d_vld[2], d_ovf[2]}), 2);

        // Random traffic against the model, with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                 16'($urandom), $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter ACC_W, default 24: accumulator width in bits; legal range 16..48.
REQ-002 Parameter LEN, default 8: number of products summed per result; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  in_prod holds a valid product.
REQ-006 in_ready  output  1  block can accept a product this cycle.
REQ-007 in_prod  input  16  signed product from the 8x8 Booth multiplier, two's complement.
REQ-008 out_valid  output  1  out_acc holds a completed sum.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_acc  output  ACC_W  signed accumulated sum, two's complement.
REQ-011 out_ovf  output  1  sticky flag: signed overflow occurred during the current sum.

Function
REQ-012 The block SHALL implement a two-state FSM: ACC and HOLD.
REQ-013 In ACC, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-014 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-015 A product SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-016 Cycles with in_valid=0 SHALL change no state, and in_prod SHALL be ignored on those cycles.
REQ-017 On accept, acc SHALL become acc plus in_prod sign-extended to ACC_W bits.
REQ-018 On accept, the 8-bit count SHALL increment by 1.
REQ-019 When the accepted product is number LEN (count equals LEN-1 before the accept), the FSM SHALL enter HOLD on the next edge.
REQ-020 out_valid SHALL therefore rise exactly 1 cycle after the LEN-th accept; the final product SHALL be included in out_acc.
REQ-021 out_acc SHALL equal the acc register at all times, including partial sums during ACC.
REQ-022 In HOLD, out_acc and out_ovf SHALL stay stable until out_ready=1; in_valid SHALL be ignored.
REQ-023 A cycle in HOLD with out_ready=1 SHALL clear acc, count and ovf to 0 and return the FSM to ACC.
REQ-024 Minimum period per result SHALL be LEN+1 cycles.
REQ-025 A signed overflow SHALL be detected when both operands have the same sign and the sum sign differs from it.
REQ-026 On overflow, out_ovf SHALL be set and SHALL remain set until the next HOLD-exit or reset.
REQ-027 With LEN=1, every accept SHALL go directly to HOLD.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force: FSM=ACC, acc=0, count=0, ovf=0.
REQ-029 Output values under reset SHALL be in_ready=1, out_valid=0, out_acc=0, out_ovf=0.
REQ-030 Reset SHALL take priority over any handshake in the same cycle.
REQ-031 Reset mid-sum or during HOLD SHALL discard the partial or pending result.

Configuration
REQ-032 The feature SHALL be controlled by macro MAC_ACCUMULATOR_SATURATE_EN.
REQ-033 With the macro defined, an overflowing add SHALL clamp acc to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow).
REQ-034 With the macro defined, subsequent adds SHALL start from the clamped value.
REQ-035 Without the macro, acc SHALL wrap modulo 2^ACC_W.
REQ-036 out_ovf behaviour SHALL be identical in both builds.

Verification
REQ-037 Reset: assert rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_acc=0, out_ovf=0.
REQ-038 Sum: LEN=8, ACC_W=24; 8 back-to-back products of 16129 -> out_valid 1 cycle after the 8th accept, out_acc=129032, out_ovf=0.
REQ-039 Backpressure and bubbles: in_valid toggled 1/0 across the sum, then out_ready=0 for 5 cycles -> bubbles leave count unchanged; out_acc stable and in_ready=0 throughout HOLD; out_ready=1 -> next cycle in_ready=1, out_acc=0.
REQ-040 Overflow: ACC_W=16, LEN=4; products 16384 x4.
  - Wrap build: partial sums 16384, -32768, -16384, 0 -> out_acc=0, out_ovf=1.
  - Saturate build: out_acc=32767, out_ovf=1.
REQ-041 Reset mid-sum: LEN=8; 3 accepts of 1000, then rst_n=0 for 1 cycle, then 8 products of 1 -> out_acc=8.
REQ-042 Negative values: LEN=2; products -16256 and -16256 -> out_acc=-32512 (ACC_W=24), out_ovf=0.
